// File: rtl/toy_mem_pkg.sv
// -----------------------------------------------------------------------------
// toy_mem_pkg
// Shared definitions for the toy processor memory/I-O subsystem:
//   - memory-map constants (top of RAM, output latch, synchronised input)
//   - loader/run state machine encoding
// -----------------------------------------------------------------------------
package toy_mem_pkg;

    localparam logic [7:0] RAM_TOP       = 8'hFD;
    localparam logic [7:0] ADDR_OUT_PORT = 8'hFE;
    localparam logic [7:0] ADDR_IN_PORT  = 8'hFF;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RELEASE,
        ST_RUN
    } state_t;

endpackage

// File: rtl/toy_ram256.sv
// -----------------------------------------------------------------------------
// toy_ram256
// Single-port synchronous RAM, 256 x 8, registered read. Contents are not
// reset. rdata only changes on a read, so it holds between reads.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable (writes wdata to mem[addr])
//   re     in   read enable (captures mem[addr] into rdata)
//   addr   in   8-bit address shared by read and write
//   wdata  in   8-bit write data
//   rdata  out  8-bit registered read data
// -----------------------------------------------------------------------------
module toy_ram256
    import toy_mem_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic       re,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] mem [256];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/toy_mem_system.sv
// -----------------------------------------------------------------------------
// toy_mem_system
// Memory and I/O target for the toy processor bus, plus a program loader.
// After reset the loader fills RAM while the processor is held in reset;
// the beat flagged LD_LAST starts a short release countdown, after which
// the processor runs and its bus accesses are serviced.
// Memory map: 0x00-0xFD RAM, 0xFE output latch (r/w), 0xFF synchronised
// IN_PORT (read-only).
// Ports:
//   CLK, RESET_N      clock (rising edge), asynchronous active-low reset
//   MEM_EN, RORW      bus strobe, 1 = read / 0 = write
//   ADD, D_OUT        bus address and write data
//   D_IN              registered read data, held until the next read
//   LD_VALID/LD_READY loader handshake; LD_ADDR/LD_DATA beat payload
//   LD_LAST           final beat of a load
//   LD_RESTART        re-enter load mode (honoured only while running)
//   LD_COUNT          accepted beats since entering load, saturating at 255
//   IN_PORT           asynchronous external input
//   OUT_PORT          memory-mapped output latch
//   CPU_HOLD          active-high reset to the processor
// -----------------------------------------------------------------------------
module toy_mem_system
    import toy_mem_pkg::*;
#(
    parameter int RELEASE_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       MEM_EN,
    input  logic       RORW,
    input  logic [7:0] ADD,
    input  logic [7:0] D_OUT,
    output logic [7:0] D_IN,
    input  logic       LD_VALID,
    output logic       LD_READY,
    input  logic [7:0] LD_ADDR,
    input  logic [7:0] LD_DATA,
    input  logic       LD_LAST,
    input  logic       LD_RESTART,
    output logic [7:0] LD_COUNT,
    input  logic [7:0] IN_PORT,
    output logic [7:0] OUT_PORT,
    output logic       CPU_HOLD
);

    localparam int REL_W = (RELEASE_CYCLES < 2) ? 1 : $clog2(RELEASE_CYCLES + 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t            state;
    state_t            state_nxt;
    logic [REL_W-1:0]  rel_cnt;
    logic [7:0]        ld_count;
    logic [7:0]        out_port;
    logic [7:0]        in_meta_p1;
    logic [7:0]        in_sync_p2;
    logic              rd_sel_ram;
    logic [7:0]        rd_io;

    logic              ld_accept;
    logic              bus_rd;
    logic              bus_wr;
    logic              ram_we;
    logic              ram_re;
    logic [7:0]        ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    // Loader beats only count in LOAD; bus accesses only in RUN. The two
    // are therefore never active together and can share the RAM port.
    assign ld_accept = LD_VALID && (state == ST_LOAD);
    assign bus_rd    = (state == ST_RUN) && MEM_EN && RORW;
    assign bus_wr    = (state == ST_RUN) && MEM_EN && !RORW;

    assign ram_addr  = (state == ST_LOAD) ? LD_ADDR : ADD;
    assign ram_wdata = (state == ST_LOAD) ? LD_DATA : D_OUT;
    assign ram_we    = ld_accept ? (LD_ADDR <= RAM_TOP) : (bus_wr && (ADD <= RAM_TOP));
    assign ram_re    = bus_rd && (ADD <= RAM_TOP);

    toy_ram256 u_ram (
        .clk   (CLK),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        LD_READY  = 1'b0;
        CPU_HOLD  = 1'b1;
        case (state)
            ST_LOAD: begin
                LD_READY = 1'b1;
                if (ld_accept && LD_LAST) begin
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Counter is loaded on the LD_LAST edge and leaves at zero,
                // giving RELEASE_CYCLES+1 edges of hold after that beat.
                if (rel_cnt == '0) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                CPU_HOLD = 1'b0;
                if (LD_RESTART) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rel_cnt <= '0;
        end else if (ld_accept && LD_LAST) begin
            rel_cnt <= REL_W'(RELEASE_CYCLES);
        end else if ((state == ST_RELEASE) && (rel_cnt != '0)) begin
            rel_cnt <= rel_cnt - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ld_count <= 8'h00;
        end else if ((state == ST_RUN) && LD_RESTART) begin
            ld_count <= 8'h00;
        end else if (ld_accept) begin
            ld_count <= sat_inc(ld_count);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_port <= 8'h00;
        end else if (bus_wr && (ADD == ADDR_OUT_PORT)) begin
            out_port <= D_OUT;
        end
    end

    // ---- stage p1: first synchroniser flop (may go metastable) ----
    // ---- stage p2: second flop, the value visible at ADDR_IN_PORT ----
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            in_meta_p1 <= 8'h00;
            in_sync_p2 <= 8'h00;
        end else begin
            in_meta_p1 <= IN_PORT;
            in_sync_p2 <= in_meta_p1;
        end
    end

    // RAM data is registered inside the RAM; I/O reads are captured here.
    // rd_sel_ram remembers which source the last read targeted so D_IN
    // holds across idle cycles and writes, and is zero straight from reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_sel_ram <= 1'b0;
            rd_io      <= 8'h00;
        end else if (bus_rd) begin
            rd_sel_ram <= (ADD <= RAM_TOP);
            rd_io      <= (ADD == ADDR_OUT_PORT) ? out_port : in_sync_p2;
        end
    end

    assign D_IN     = rd_sel_ram ? ram_rdata : rd_io;
    assign OUT_PORT = out_port;
    assign LD_COUNT = ld_count;

endmodule

// File: tb/tb_toy_mem_system.sv
module tb_toy_mem_system;

    localparam int R = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_en = 1'b0;
    logic       rorw = 1'b0;
    logic [7:0] add = 8'h00;
    logic [7:0] d_out = 8'h00;
    logic [7:0] d_in;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [7:0] ld_addr = 8'h00;
    logic [7:0] ld_data = 8'h00;
    logic       ld_last = 1'b0;
    logic       ld_restart = 1'b0;
    logic [7:0] ld_count;
    logic [7:0] in_port = 8'h00;
    logic [7:0] out_port;
    logic       cpu_hold;

    int n_checks = 0;
    int n_pass = 0;

    toy_mem_system #(.RELEASE_CYCLES(R)) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .MEM_EN     (mem_en),
        .RORW       (rorw),
        .ADD        (add),
        .D_OUT      (d_out),
        .D_IN       (d_in),
        .LD_VALID   (ld_valid),
        .LD_READY   (ld_ready),
        .LD_ADDR    (ld_addr),
        .LD_DATA    (ld_data),
        .LD_LAST    (ld_last),
        .LD_RESTART (ld_restart),
        .LD_COUNT   (ld_count),
        .IN_PORT    (in_port),
        .OUT_PORT   (out_port),
        .CPU_HOLD   (cpu_hold)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: memory image, beat count, output latch, last read
    // value, IN_PORT history, and the edge after which the processor runs.
    // ------------------------------------------------------------------
    logic [7:0] m_mem [256];
    bit         m_known [256];
    int         edge_n = 0;
    bit         m_loading = 1'b1;
    int         m_run_from = 0;
    logic [7:0] m_count = 8'h00;
    logic [7:0] m_out = 8'h00;
    logic [7:0] m_din = 8'h00;
    bit         m_din_ok = 1'b1;
    logic [7:0] in_hist [$] = '{8'h00, 8'h00};
    logic [7:0] sync_val;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_n     = 0;
            m_loading  = 1'b1;
            m_run_from = 0;
            m_count    = 8'h00;
            m_out      = 8'h00;
            m_din      = 8'h00;
            m_din_ok   = 1'b1;
            in_hist    = '{8'h00, 8'h00};
        end else begin
            edge_n++;
            sync_val = in_hist[1];   // IN_PORT as sampled two edges ago
            if (!m_loading && edge_n > m_run_from) begin
                if (mem_en && rorw) begin
                    m_din_ok = 1'b1;
                    if (add == 8'hFF)      m_din = sync_val;
                    else if (add == 8'hFE) m_din = m_out;
                    else begin
                        m_din    = m_mem[add];
                        m_din_ok = m_known[add];
                    end
                end else if (mem_en) begin
                    if (add <= 8'hFD) begin
                        m_mem[add]   = d_out;
                        m_known[add] = 1'b1;
                    end else if (add == 8'hFE) begin
                        m_out = d_out;
                    end
                end
                if (ld_restart) begin
                    m_loading = 1'b1;
                    m_count   = 8'h00;
                end
            end else if (m_loading && ld_valid) begin
                if (ld_addr <= 8'hFD) begin
                    m_mem[ld_addr]   = ld_data;
                    m_known[ld_addr] = 1'b1;
                end
                if (m_count != 8'hFF) m_count = m_count + 8'd1;
                if (ld_last) begin
                    m_loading  = 1'b0;
                    m_run_from = edge_n + R + 1;
                end
            end
            in_hist.push_front(in_port);
            void'(in_hist.pop_back());
        end
    end

    always @(negedge clk) begin
        check("cpu_hold", {7'b0, cpu_hold}, {7'b0, !(!m_loading && edge_n >= m_run_from)});
        check("ld_ready", {7'b0, ld_ready}, {7'b0, m_loading});
        check("ld_count", ld_count, m_count);
        check("out_port", out_port, m_out);
        if (m_din_ok) check("d_in", d_in, m_din);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change on the falling edge.
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        mem_en = 1'b1; rorw = 1'b0; add = a; d_out = d;
        @(negedge clk);
        mem_en = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a);
        mem_en = 1'b1; rorw = 1'b1; add = a;
        @(negedge clk);
        mem_en = 1'b0; rorw = 1'b0;
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] d, input logic last);
        ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        tick(2);
        check("rst d_in", d_in, 8'h00);
        check("rst out_port", out_port, 8'h00);
        check("rst ld_count", ld_count, 8'h00);
        check("rst cpu_hold", {7'b0, cpu_hold}, 8'h01);
        check("rst ld_ready", {7'b0, ld_ready}, 8'h01);
        rst_n = 1'b1;
        tick(1);

        // Load and release
        beat(8'h00, 8'h01, 1'b0);
        beat(8'h01, 8'hAA, 1'b0);
        beat(8'h02, 8'h04, 1'b1);
        check("load count", ld_count, 8'd3);
        check("hold +0", {7'b0, cpu_hold}, 8'h01);
        check("ready release", {7'b0, ld_ready}, 8'h00);
        tick(1);
        check("hold +1", {7'b0, cpu_hold}, 8'h01);
        tick(1);
        check("hold +2", {7'b0, cpu_hold}, 8'h01);
        tick(1);
        check("hold +3", {7'b0, cpu_hold}, 8'h00);

        // RAM read/write in RUN
        bus_read(8'h01);
        check("rd 01", d_in, 8'hAA);
        bus_write(8'h10, 8'hFF);
        check("d_in held over write", d_in, 8'hAA);
        bus_read(8'h10);
        check("rd 10", d_in, 8'hFF);
        bus_write(8'h05, 8'h11);
        bus_write(8'hFD, 8'h5D);
        bus_read(8'hFD);
        check("rd FD", d_in, 8'h5D);

        // Memory-mapped I/O
        bus_write(8'hFE, 8'hCC);
        check("out_port", out_port, 8'hCC);
        in_port = 8'h0F;
        tick(3);
        bus_read(8'hFF);
        check("rd FF", d_in, 8'h0F);
        bus_write(8'hFF, 8'h55);
        bus_read(8'hFF);
        check("rd FF after write", d_in, 8'h0F);
        in_port = 8'hF0;
        bus_read(8'hFF);
        check("sync edge1", d_in, 8'h0F);
        bus_read(8'hFF);
        check("sync edge2", d_in, 8'h0F);
        bus_read(8'hFF);
        check("sync edge3", d_in, 8'hF0);
        bus_read(8'hFE);
        check("rd FE", d_in, 8'hCC);

        // Hold gating and restart
        ld_restart = 1'b1; mem_en = 1'b1; rorw = 1'b0; add = 8'h06; d_out = 8'h33;
        @(negedge clk);
        ld_restart = 1'b0; mem_en = 1'b0;
        check("restart hold", {7'b0, cpu_hold}, 8'h01);
        check("restart count", ld_count, 8'h00);
        check("restart ready", {7'b0, ld_ready}, 8'h01);
        bus_write(8'h05, 8'h77);
        bus_read(8'h01);
        check("no read in LOAD", d_in, 8'hCC);
        beat(8'hFE, 8'h99, 1'b0);
        beat(8'h20, 8'h5A, 1'b0);
        beat(8'h21, 8'h3C, 1'b1);
        check("reload count", ld_count, 8'd3);
        tick(R + 1);
        check("rerun hold", {7'b0, cpu_hold}, 8'h00);
        beat(8'h21, 8'hEE, 1'b1);
        check("beat in RUN count", ld_count, 8'd3);
        bus_read(8'h05);
        check("rd 05 unchanged", d_in, 8'h11);
        bus_read(8'h06);
        check("rd 06", d_in, 8'h33);
        bus_read(8'hFE);
        check("loader skipped FE", d_in, 8'hCC);
        bus_read(8'h20);
        check("rd 20", d_in, 8'h5A);
        bus_read(8'h21);
        check("rd 21", d_in, 8'h3C);

        // Saturation and asynchronous reset
        ld_restart = 1'b1;
        tick(1);
        ld_restart = 1'b0;
        check("sat start count", ld_count, 8'h00);
        for (int i = 0; i < 260; i++) begin
            logic [7:0] a8;
            a8 = 8'(i);
            beat(a8, a8 ^ 8'h5A, 1'b0);
            if (i == 253) check("count 254", ld_count, 8'd254);
        end
        check("count saturated", ld_count, 8'hFF);
        ld_valid = 1'b1; ld_addr = 8'h31; ld_data = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check("async d_in", d_in, 8'h00);
        check("async out_port", out_port, 8'h00);
        check("async ld_count", ld_count, 8'h00);
        check("async cpu_hold", {7'b0, cpu_hold}, 8'h01);
        check("async ld_ready", {7'b0, ld_ready}, 8'h01);
        ld_valid = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        beat(8'h40, 8'h12, 1'b1);
        tick(R + 1);
        check("post-reset run", {7'b0, cpu_hold}, 8'h00);
        bus_read(8'h30);
        check("ram kept 30", d_in, 8'h6A);
        bus_read(8'h00);
        check("ram kept 00", d_in, 8'h5A);
        bus_read(8'hFE);
        check("out_port cleared", d_in, 8'h00);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
